// File: rtl/bus_arbiter8_pkg.sv
// Shared constants and state encoding for the eight-way round-robin bus arbiter.
package bus_arbiter8_pkg;

  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_e;

endpackage

// File: rtl/bus_arbiter8_rr_pick8.sv
// Combinational round-robin picker: rotate requests by ptr, find first set, un-rotate.
module rr_pick8
  import bus_arbiter8_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [SEL_W-1:0]   winner,
  output logic               any_req
);

  logic [NUM_REQ-1:0] rot;
  logic [SEL_W-1:0]   idx;

  always_comb begin
    rot = NUM_REQ'({req, req} >> ptr);
    idx = '0;
    // Scan downward so the lowest set bit (closest to ptr) wins.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) idx = SEL_W'(i);
    end
    winner = idx + ptr;
  end

  assign any_req = |req;

endmodule

// File: rtl/bus_arbiter8.sv
// Round-robin owner of the shared 16-bit datapath; tenure capped at MAX_HOLD grant cycles.
module bus_arbiter8
  import bus_arbiter8_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic               busy,
  output logic               timeout
);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [HOLD_W-1:0]  cnt_q, cnt_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               busy_q, busy_d;
  logic               timeout_q, timeout_d;

  logic [SEL_W-1:0]   winner;
  logic               any_req;
  logic               owner_req;
  logic               at_max;
  logic               release_w;
  logic               forced_w;

  rr_pick8 u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .winner  (winner),
    .any_req (any_req)
  );

  assign owner_req = req[sel_q];
  assign at_max    = (cnt_q == HOLD_W'(MAX_HOLD));
  assign release_w = (state_q == ST_OWN) && (!owner_req || at_max);
  assign forced_w  = (state_q == ST_OWN) && owner_req && at_max;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      sel_q     <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = ST_OWN;
          cnt_d   = HOLD_W'(1);
        end
      end
      ST_OWN: begin
        if (release_w) begin
          state_d = ST_IDLE;
          ptr_d   = sel_q + SEL_W'(1);
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + HOLD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output registers load from here; sel keeps the last owner while idle.
  always_comb begin
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          gnt_d  = NUM_REQ'(1) << winner;
          sel_d  = winner;
          busy_d = 1'b1;
        end else begin
          gnt_d  = '0;
          busy_d = 1'b0;
        end
      end
      ST_OWN: begin
        if (release_w) begin
          gnt_d     = '0;
          busy_d    = 1'b0;
          timeout_d = forced_w;
        end
      end
      default: begin
        gnt_d  = '0;
        busy_d = 1'b0;
      end
    endcase
  end

  assign gnt     = gnt_q;
  assign sel     = sel_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule
